// File: rtl/term_char_buf_pkg.sv
// Shared constants and types for the scrolling terminal character buffer.
package term_char_buf_pkg;

    localparam logic [7:0] ASCII_BS  = 8'h08;
    localparam logic [7:0] ASCII_TAB = 8'h09;
    localparam logic [7:0] ASCII_LF  = 8'h0A;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_ESC = 8'h1B;
    localparam logic [7:0] ASCII_DEL = 8'h7F;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;

    typedef enum logic [1:0] {
        IDLE,
        CLR_ROW,
        CLR_ALL
    } state_t;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/term_char_buf_if.sv
// Character input handshake and pixel read port of the terminal buffer.
interface term_char_buf_if #(
    parameter int p_hchar_bits = 7,
    parameter int p_vchar_bits = 5
);
    logic [7:0]              ascii;
    logic                    ascii_val;
    logic                    ascii_rdy;
    logic [p_hchar_bits-1:0] read_hchar;
    logic [p_vchar_bits-1:0] read_vchar;
    logic [2:0]              read_hoffset;
    logic [3:0]              read_voffset;
    logic                    read_lit;
    logic                    out_of_bounds;

    modport master (
        output ascii, ascii_val, read_hchar, read_vchar, read_hoffset, read_voffset,
        input  ascii_rdy, read_lit, out_of_bounds
    );

    modport slave (
        input  ascii, ascii_val, read_hchar, read_vchar, read_hoffset, read_voffset,
        output ascii_rdy, read_lit, out_of_bounds
    );
endinterface

// File: rtl/term_char_buf_charlut.sv
// CharLUT: 8x16 glyph pixel lookup. Carries a reduced glyph set; other
// printable codes render as a box outline, code 0 and space are blank.
module CharLUT
    import term_char_buf_pkg::*;
(
    input  logic [7:0] code,
    input  logic [2:0] hoffset,
    input  logic [3:0] voffset,
    output logic       lit
);
    localparam logic [GLYPH_W*GLYPH_H-1:0] G_A   = 128'h00001038_6CC6C6FE_C6C6C6C6_00000000;
    localparam logic [GLYPH_W*GLYPH_H-1:0] G_B   = 128'h0000FC66_66667C66_666666FC_00000000;
    localparam logic [GLYPH_W*GLYPH_H-1:0] G_C   = 128'h00003C66_C2C0C0C0_C0C2663C_00000000;
    localparam logic [GLYPH_W*GLYPH_H-1:0] G_X   = 128'h0000C6C6_6C7C3838_7C6CC6C6_00000000;
    localparam logic [GLYPH_W*GLYPH_H-1:0] G_BOX = 128'h00007E42_42424242_4242427E_00000000;

    logic [GLYPH_W*GLYPH_H-1:0] glyph;
    logic [GLYPH_W-1:0]         row_bits;

    // Row 0 sits in the top byte, pixel column 0 in the MSB of each row.
    always_comb begin
        case (code)
            8'h41:   glyph = G_A;
            8'h42:   glyph = G_B;
            8'h43:   glyph = G_C;
            8'h58:   glyph = G_X;
            default: glyph = (code > 8'h20 && code < 8'h7F) ? G_BOX : '0;
        endcase
        row_bits = glyph[{~voffset, 3'b000} +: GLYPH_W];
        lit      = row_bits[~hoffset];
    end
endmodule

// File: rtl/term_char_buf.sv
// Scrolling terminal character grid with cursor, multi-cycle clears and a
// registered glyph-pixel read port for the VGA driver.
module term_char_buf
    import term_char_buf_pkg::*;
#(
    parameter int p_num_rows     = 16,
    parameter int p_num_cols     = 32,
    parameter int p_tab_width    = 4,
    parameter int p_blink_cycles = 25_000_000,
    parameter int p_hchar_bits   = 7,
    parameter int p_vchar_bits   = 5
) (
    input  logic           clk,
    input  logic           rst,
    term_char_buf_if.slave bus
);
    localparam int RW = $clog2(p_num_rows);
    localparam int CW = $clog2(p_num_cols);
    localparam int AW = RW + CW;
    localparam int BW = $clog2(p_blink_cycles + 1);

    localparam logic [CW-1:0] LAST_COL   = CW'(p_num_cols - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(p_num_rows - 1);
    localparam logic [CW-1:0] TAB_MASK   = CW'(p_tab_width - 1);
    localparam logic [CW:0]   NUM_COLS_W = (CW+1)'(p_num_cols);
    localparam logic [BW-1:0] BLINK_LAST = BW'(p_blink_cycles - 1);

    state_t        state, state_n;
    logic [CW-1:0] cx, cx_n;
    logic [RW-1:0] cy, cy_n, top, top_n;
    logic [AW-1:0] clr_cnt, clr_cnt_n;
    logic          accept, newline;
    logic [CW:0]   tab_next;
    logic [RW-1:0] row_phys, row_prev;
    logic [CW-1:0] cx_prev;

    logic          we;
    logic [AW-1:0] waddr, raddr;
    logic [7:0]    wdata, rd_code;
    logic [7:0]    mem [p_num_rows*p_num_cols];

    logic [BW-1:0] blink_cnt;
    logic          blink_on;

    logic [p_hchar_bits-1:0] hchar;
    logic [p_vchar_bits-1:0] vchar;
    logic                    in_grid, cur_cell;
    logic                    oob_q, cur_q, glyph_lit;
    logic [2:0]              hoff_q;
    logic [3:0]              voff_q;

    assign accept    = bus.ascii_val & (state == IDLE) & ~rst;
    assign tab_next  = {1'b0, cx | TAB_MASK} + 1'b1;
    assign row_phys  = top + cy;
    assign row_prev  = row_phys - 1'b1;
    assign cx_prev   = cx - 1'b1;
    assign bus.ascii_rdy = (state == IDLE) & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLR_ALL;
            cx      <= '0;
            cy      <= '0;
            top     <= '0;
            clr_cnt <= '0;
        end else begin
            state   <= state_n;
            cx      <= cx_n;
            cy      <= cy_n;
            top     <= top_n;
            clr_cnt <= clr_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cx_n      = cx;
        cy_n      = cy;
        top_n     = top;
        clr_cnt_n = clr_cnt;
        newline   = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (is_printable(bus.ascii)) begin
                    if (cx == LAST_COL) newline = 1'b1;
                    else                cx_n    = cx + 1'b1;
                end else begin
                    case (bus.ascii)
                        ASCII_LF: newline = 1'b1;
                        ASCII_CR: cx_n = '0;
                        ASCII_TAB: begin
                            if (tab_next >= NUM_COLS_W) newline = 1'b1;
                            else                        cx_n    = tab_next[CW-1:0];
                        end
                        ASCII_BS, ASCII_DEL: begin
                            if (cx != '0) begin
                                cx_n = cx_prev;
                            end else if (cy != '0) begin
                                cy_n = cy - 1'b1;
                                cx_n = LAST_COL;
                            end
                        end
                        ASCII_ESC: begin
                            cx_n      = '0;
                            cy_n      = '0;
                            top_n     = '0;
                            clr_cnt_n = '0;
                            state_n   = CLR_ALL;
                        end
                        default: ;
                    endcase
                end
                // On the bottom row a new line scrolls by advancing top.
                if (newline) begin
                    cx_n = '0;
                    if (cy != LAST_ROW) cy_n  = cy + 1'b1;
                    else                top_n = top + 1'b1;
                    clr_cnt_n = '0;
                    state_n   = CLR_ROW;
                end
            end
            CLR_ROW: begin
                clr_cnt_n = clr_cnt + 1'b1;
                if (clr_cnt[CW-1:0] == LAST_COL) begin
                    clr_cnt_n = '0;
                    state_n   = IDLE;
                end
            end
            CLR_ALL: begin
                clr_cnt_n = clr_cnt + 1'b1;
                if (&clr_cnt) begin
                    clr_cnt_n = '0;
                    state_n   = IDLE;
                end
            end
            default: state_n = CLR_ALL;
        endcase
    end

    // Single write port shared by character writes, backspace and clears.
    always_comb begin
        we    = 1'b0;
        waddr = {row_phys, cx};
        wdata = '0;
        case (state)
            IDLE: if (accept) begin
                if (is_printable(bus.ascii)) begin
                    we    = 1'b1;
                    wdata = bus.ascii;
                end else if (bus.ascii == ASCII_BS || bus.ascii == ASCII_DEL) begin
                    if (cx != '0) begin
                        we    = 1'b1;
                        waddr = {row_phys, cx_prev};
                    end else if (cy != '0) begin
                        we    = 1'b1;
                        waddr = {row_prev, LAST_COL};
                    end
                end
            end
            CLR_ROW: begin
                we    = 1'b1;
                waddr = {row_phys, clr_cnt[CW-1:0]};
            end
            CLR_ALL: begin
                we    = 1'b1;
                waddr = clr_cnt;
            end
            default: ;
        endcase
    end

    // Read-first RAM: a same-cycle read of the written cell returns old data.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rd_code <= mem[raddr];
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign hchar    = bus.read_hchar;
    assign vchar    = bus.read_vchar;
    assign in_grid  = (32'(hchar) < p_num_cols) && (32'(vchar) < p_num_rows);
    assign cur_cell = (32'(hchar) == 32'(cx)) && (32'(vchar) == 32'(cy));
    assign raddr    = {top + vchar[RW-1:0], hchar[CW-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            oob_q  <= 1'b1;
            cur_q  <= 1'b0;
            hoff_q <= '0;
            voff_q <= '0;
        end else begin
            oob_q  <= ~in_grid;
            cur_q  <= in_grid & cur_cell & blink_on & (state == IDLE) &
                      (bus.read_voffset == 4'(GLYPH_H - 1)) &
                      (bus.read_hoffset != 3'(GLYPH_W - 1));
            hoff_q <= bus.read_hoffset;
            voff_q <= bus.read_voffset;
        end
    end

    CharLUT u_lut (
        .code    (rd_code),
        .hoffset (hoff_q),
        .voffset (voff_q),
        .lit     (glyph_lit)
    );

    assign bus.out_of_bounds = oob_q;
    assign bus.read_lit      = ~oob_q & (cur_q | glyph_lit);

endmodule

// File: tb/tb_term_char_buf.sv
// Directed bench for term_char_buf: reset clear, writes, wrap, scroll,
// tab/backspace, stall, reset abort and cursor blink.
module tb_term_char_buf;
    import term_char_buf_pkg::*;

    localparam int BLINK = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    term_char_buf_if #(.p_hchar_bits(7), .p_vchar_bits(5)) bus ();

    term_char_buf #(
        .p_num_rows(16), .p_num_cols(32), .p_tab_width(4),
        .p_blink_cycles(BLINK), .p_hchar_bits(7), .p_vchar_bits(5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input int h, input int v, input int ho, input int vo);
        bus.read_hchar   = 7'(h);
        bus.read_vchar   = 5'(v);
        bus.read_hoffset = 3'(ho);
        bus.read_voffset = 4'(vo);
        tick();
    endtask

    task automatic pix(input string tag, input int h, input int v, input int ho,
                       input int vo, input logic exp);
        rd(h, v, ho, vo);
        chk(tag, 32'(bus.read_lit), 32'(exp));
    endtask

    task automatic send(input logic [7:0] c, output int waited);
        waited        = 0;
        bus.ascii     = c;
        bus.ascii_val = 1'b1;
        while (!bus.ascii_rdy && waited < 2000) begin
            tick();
            waited++;
        end
        if (!bus.ascii_rdy) chk("send_timeout", 32'(bus.ascii_rdy), 32'd1);
        tick();
        bus.ascii_val = 1'b0;
    endtask

    task automatic sendc(input logic [7:0] c);
        int w;
        send(c, w);
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (!bus.ascii_rdy && n < 2000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        bus.ascii        = '0;
        bus.ascii_val    = 1'b0;
        bus.read_hchar   = '0;
        bus.read_vchar   = '0;
        bus.read_hoffset = '0;
        bus.read_voffset = '0;

        // Reset and power-up clear
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_rdy", 32'(bus.ascii_rdy), 32'd0);
        chk("rst_oob", 32'(bus.out_of_bounds), 32'd1);
        chk("rst_lit", 32'(bus.read_lit), 32'd0);
        rst = 1'b0;
        wait_rdy(n);
        chk("rst_clear_len", n, 512);
        pix("rst_cursor_00", 0, 0, 0, 15, 1'b1);
        pix("rst_cursor_h7", 0, 0, 7, 15, 1'b0);
        pix("rst_blank_10", 1, 0, 0, 15, 1'b0);
        pix("rst_blank_53", 5, 3, 3, 7, 1'b0);
        rd(40, 0, 0, 15);
        chk("oob_h40", 32'(bus.out_of_bounds), 32'd1);
        chk("oob_h40_lit", 32'(bus.read_lit), 32'd0);
        rd(64, 0, 0, 15);
        chk("oob_h64_alias", 32'(bus.out_of_bounds), 32'd1);
        chk("oob_h64_lit", 32'(bus.read_lit), 32'd0);
        rd(0, 16, 0, 15);
        chk("oob_v16", 32'(bus.out_of_bounds), 32'd1);
        chk("oob_v16_lit", 32'(bus.read_lit), 32'd0);
        rd(31, 15, 0, 0);
        chk("inb_corner", 32'(bus.out_of_bounds), 32'd0);

        // Single write of 'A'
        sendc(8'h41);
        pix("A_r7_h0", 0, 0, 0, 7, 1'b1);
        pix("A_r7_h7", 0, 0, 7, 7, 1'b0);
        pix("A_r3_h0", 0, 0, 0, 3, 1'b0);
        pix("A_r3_h3", 0, 0, 3, 3, 1'b1);
        pix("A_cursor_left", 0, 0, 0, 15, 1'b0);
        pix("A_cursor_10", 1, 0, 0, 15, 1'b1);

        // Read of the cursor cell in the cycle it is written returns old data
        bus.read_hchar = 7'd1; bus.read_vchar = 5'd0;
        bus.read_hoffset = 3'd1; bus.read_voffset = 4'd7;
        send(8'h42, n);
        chk("wr_rd_same_old", 32'(bus.read_lit), 32'd0);
        tick();
        chk("wr_rd_next_new", 32'(bus.read_lit), 32'd1);

        // Row wrap
        sendc(ASCII_CR);
        for (int i = 0; i < 32; i++) sendc(8'h42);
        wait_rdy(n);
        chk("wrap_clear_len", n, 32);
        pix("wrap_col0", 0, 0, 1, 7, 1'b1);
        pix("wrap_col31", 31, 0, 1, 7, 1'b1);
        pix("wrap_row1_blank", 5, 1, 1, 7, 1'b0);
        pix("wrap_cursor_01", 0, 1, 0, 15, 1'b1);

        // ESC clears the screen
        sendc(ASCII_ESC);
        wait_rdy(n);
        chk("esc_clear_len", n, 512);
        pix("esc_blank", 0, 0, 1, 7, 1'b0);
        pix("esc_cursor", 0, 0, 0, 15, 1'b1);

        // Scroll
        sendc(8'h58);
        sendc(ASCII_LF);
        wait_rdy(n);
        chk("lf_clear_len", n, 32);
        sendc(8'h41);
        for (int i = 0; i < 15; i++) begin
            sendc(ASCII_LF);
            wait_rdy(n);
        end
        pix("scroll_A_up", 0, 0, 0, 7, 1'b1);
        pix("scroll_row1_blank", 0, 1, 0, 7, 1'b0);
        pix("scroll_X_gone", 0, 15, 0, 2, 1'b0);
        pix("scroll_cursor", 0, 15, 0, 15, 1'b1);

        // Tab
        sendc(8'h41);
        sendc(ASCII_TAB);
        pix("tab_cursor_4", 4, 15, 0, 15, 1'b1);
        pix("tab_cursor_not1", 1, 15, 0, 15, 1'b0);

        // Backspace across a line boundary
        sendc(ASCII_ESC);
        wait_rdy(n);
        for (int i = 0; i < 32; i++) sendc(8'h42);
        wait_rdy(n);
        sendc(ASCII_BS);
        pix("bs_wrap_zeroed", 31, 0, 1, 7, 1'b0);
        pix("bs_wrap_keep30", 30, 0, 1, 7, 1'b1);
        pix("bs_wrap_cursor", 31, 0, 0, 15, 1'b1);
        sendc(ASCII_CR);
        sendc(ASCII_BS);
        pix("bs_origin_cell", 0, 0, 1, 7, 1'b1);
        pix("bs_origin_cursor", 0, 0, 0, 15, 1'b1);
        sendc(ASCII_TAB);
        sendc(ASCII_DEL);
        pix("del_zeroed", 3, 0, 1, 7, 1'b0);
        pix("del_keep4", 4, 0, 1, 7, 1'b1);
        pix("del_cursor", 3, 0, 0, 15, 1'b1);
        sendc(ASCII_TAB);
        pix("tab_from3", 4, 0, 0, 15, 1'b1);

        // Tab past the last column starts a new line
        sendc(ASCII_LF);
        wait_rdy(n);
        sendc(ASCII_BS);
        sendc(ASCII_TAB);
        wait_rdy(n);
        chk("tab_wrap_clear_len", n, 32);
        pix("tab_wrap_cursor", 0, 1, 0, 15, 1'b1);

        // Held valid during a row clear
        sendc(ASCII_LF);
        send(8'h43, n);
        chk("stall_wait", n, 32);
        pix("stall_C", 0, 2, 2, 3, 1'b1);
        pix("stall_once", 1, 2, 2, 3, 1'b0);
        pix("stall_cursor", 1, 2, 0, 15, 1'b1);

        // Reset in the middle of a row clear
        sendc(ASCII_LF);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_rdy(n);
        chk("abort_clear_len", n, 512);
        pix("abort_C_gone", 0, 2, 2, 3, 1'b0);
        pix("abort_cursor", 0, 0, 0, 15, 1'b1);

        // Blink phase and restart on accept
        repeat (2700) tick();
        pix("blink_off", 0, 0, 0, 15, 1'b0);
        sendc(8'h42);
        pix("blink_restart", 1, 0, 0, 15, 1'b1);
        repeat (2980) tick();
        pix("blink_still_on", 1, 0, 0, 15, 1'b1);
        repeat (30) tick();
        pix("blink_toggled", 1, 0, 0, 15, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
